// File: rtl/modq3023_frame_accumulator_if.sv
// Residue stream in, frame-sum stream out, both valid/ready.
// The accumulator takes the slave side; the upstream reducer and downstream consumer take the master side.
interface modq3023_frame_accumulator_if #(
    parameter int W = 12
);
    logic [W-1:0] din_r;
    logic         din_valid;
    logic         din_ready;
    logic [W-1:0] dout_sum;
    logic         dout_valid;
    logic         dout_ready;

    modport master (
        output din_r,
        output din_valid,
        input  din_ready,
        input  dout_sum,
        input  dout_valid,
        output dout_ready
    );

    modport slave (
        input  din_r,
        input  din_valid,
        output din_ready,
        output dout_sum,
        output dout_valid,
        input  dout_ready
    );
endinterface

// File: rtl/modq3023_frame_accumulator.sv
// Mod-Q frame accumulator: sums FRAME_LEN residues modulo Q, one per cycle,
// and presents one reduced sum per frame, held under output backpressure.
// Out-of-range residues (Q..2Q-1) are folded once and raise a sticky err.
module modq3023_frame_accumulator #(
    parameter int Q         = 3023,
    parameter int W         = 12,
    parameter int FRAME_LEN = 256,
    parameter int CW        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic err,
    modq3023_frame_accumulator_if.slave bus
);
    localparam int             LAST_I = FRAME_LEN - 1;
    localparam int             ONE_I  = 1;
    localparam logic [W-1:0]   Q_W    = Q[W-1:0];
    localparam logic [W:0]     Q_S    = Q[W:0];
    localparam logic [CW-1:0]  LAST   = LAST_I[CW-1:0];
    localparam logic [CW-1:0]  ONE    = ONE_I[CW-1:0];

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  acc_reg;
    logic [W-1:0]  sum_reg;
    logic [CW-1:0] cnt_reg;
    logic          err_reg;

    logic          accept;
    logic          last_beat;
    logic          out_of_range;
    logic [W-1:0]  x;
    logic [W:0]    s;
    logic [W:0]    s_sub;
    logic [W-1:0]  acc_next;

    // Modular add: fold the input once (it is below 2Q), then fold the sum once.
    always_comb begin
        out_of_range = (bus.din_r >= Q_W);
        x            = out_of_range ? (bus.din_r - Q_W) : bus.din_r;
        s            = {1'b0, acc_reg} + {1'b0, x};
        s_sub        = s - Q_S;
        acc_next     = (s >= Q_S) ? s_sub[W-1:0] : s[W-1:0];
        last_beat    = (cnt_reg == LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs; clr blocks input and returns to ACCUM.
    always_comb begin
        state_next     = state_reg;
        bus.din_ready  = 1'b0;
        bus.dout_valid = 1'b0;
        accept         = 1'b0;
        case (state_reg)
            ACCUM: begin
                bus.din_ready = !clr;
                accept        = bus.din_valid && !clr;
                if (accept && last_beat) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                bus.dout_valid = 1'b1;
                if (bus.dout_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
        if (clr) begin
            state_next = ACCUM;
        end
    end

    // Accumulator, beat counter, result register and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            sum_reg <= '0;
            err_reg <= 1'b0;
        end else if (clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else if (accept) begin
            if (out_of_range) begin
                err_reg <= 1'b1;
            end
            if (last_beat) begin
                sum_reg <= acc_next;
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_reg + ONE;
            end
        end
    end

    assign bus.dout_sum = sum_reg;
    assign err          = err_reg;
endmodule

// File: tb/tb_modq3023_frame_accumulator.sv
module tb_modq3023_frame_accumulator;
    localparam int Q  = 3023;
    localparam int W  = 12;
    localparam int FL = 4;
    localparam int CW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic err;

    always #5 clk = ~clk;

    modq3023_frame_accumulator_if #(.W(W)) bus ();

    modq3023_frame_accumulator #(
        .Q(Q), .W(W), .FRAME_LEN(FL), .CW(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .err   (err),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int exp_q[$];
    int m_acc = 0;
    int m_cnt = 0;
    bit m_err = 1'b0;
    bit m_out = 1'b0;
    bit prev_stall = 1'b0;
    int prev_sum = 0;
    int outs = 0;
    int frames_sent = 0;
    bit stim_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_acc = 0; m_cnt = 0; m_err = 0; m_out = 0; prev_stall = 0;
        end else begin
            tests++;
            if (bus.dout_valid !== m_out) begin
                fails++;
                $error("FAIL dout_valid observed=%0d expected=%0d", bus.dout_valid, m_out);
            end
            tests++;
            if (bus.din_ready !== (!m_out && !clr)) begin
                fails++;
                $error("FAIL din_ready observed=%0d expected=%0d", bus.din_ready, (!m_out && !clr));
            end
            tests++;
            if (err !== m_err) begin
                fails++;
                $error("FAIL err observed=%0d expected=%0d", err, m_err);
            end
            if (prev_stall && bus.dout_valid) begin
                chk("hold_sum", int'(bus.dout_sum), prev_sum);
            end
            prev_stall = bus.dout_valid && !bus.dout_ready;
            prev_sum   = int'(bus.dout_sum);
            if (clr) begin
                if (m_out && exp_q.size() > 0) void'(exp_q.pop_front());
                m_acc = 0; m_cnt = 0; m_err = 0; m_out = 0;
            end else if (m_out) begin
                if (bus.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("queue_nonempty", 0, 1);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        chk("sum", int'(bus.dout_sum), e);
                    end
                    outs++;
                    m_out = 0;
                end
            end else if (bus.din_valid) begin
                if (int'(bus.din_r) >= Q) m_err = 1'b1;
                m_acc = (m_acc + int'(bus.din_r)) % Q;
                if (m_cnt == FL - 1) begin
                    exp_q.push_back(m_acc);
                    m_acc = 0; m_cnt = 0; m_out = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    task automatic send(input int v);
        bit ok;
        int vv;
        ok = 1'b0;
        vv = v;
        bus.din_valid = 1'b1;
        bus.din_r     = vv[W-1:0];
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.din_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic send_frame(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
        frames_sent++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din_valid  = 1'b0;
        bus.din_r      = '0;
        bus.dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_dout_valid", bus.dout_valid, 1'b0);
        chk("rst_din_ready", bus.din_ready, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_dout_sum", int'(bus.dout_sum), 0);
        @(posedge clk); #1;

        send_frame(3022, 3022, 1, 5);
        chk("t1_valid", bus.dout_valid, 1'b1);
        chk("t1_sum", int'(bus.dout_sum), 4);
        chk("t1_err", err, 1'b0);
        @(posedge clk); #1;

        bus.dout_ready = 1'b0;
        send_frame(3022, 3022, 1, 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum", int'(bus.dout_sum), 4);
            chk("bp_din_ready", bus.din_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", bus.din_ready, 1'b1);
        chk("bp_release_valid", bus.dout_valid, 1'b0);

        send_frame(1511, 1512, 0, 0);
        chk("wrap_sum", int'(bus.dout_sum), 0);
        send_frame(0, 0, 0, 0);
        chk("zero_sum", int'(bus.dout_sum), 0);
        chk("zero_valid", bus.dout_valid, 1'b1);

        send(4000);
        chk("oor_err_first", err, 1'b1);
        send(10); send(0); send(0);
        frames_sent++;
        chk("oor_sum", int'(bus.dout_sum), 987);
        send_frame(1, 2, 3, 4);
        chk("oor_sum2", int'(bus.dout_sum), 10);
        chk("oor_err_sticky", err, 1'b1);

        send(100); send(200);
        clr = 1'b1;
        bus.din_valid = 1'b1;
        bus.din_r = 12'd50;
        @(negedge clk);
        chk("clr_din_ready", bus.din_ready, 1'b0);
        @(posedge clk); #1;
        clr = 1'b0;
        bus.din_valid = 1'b0;
        chk("clr_err", err, 1'b0);
        send_frame(7, 8, 9, 10);
        chk("clr_sum", int'(bus.dout_sum), 34);

        fork
            begin
                for (int f = 0; f < 1000; f++) begin
                    for (int b = 0; b < FL; b++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk); #1;
                        end
                        send(int'($urandom_range(0, Q - 1)));
                    end
                    frames_sent++;
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk); #1;
                    bus.dout_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.dout_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_out_count", outs, frames_sent);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/modq3023_frame_accumulator.md
Name: modq3023_frame_accumulator

Overview:
- Sequential stage directly downstream of the mod-3023 Barrett reducer.
- Consumes the reducer's 12-bit residues through a valid/ready stream and accumulates them modulo Q, one residue per cycle.
- Emits one reduced sum per frame of FRAME_LEN residues, for example the per-block dot-product sum in a lattice or NTT datapath.
- Holds the result under output backpressure, and flags any out-of-range residue it receives.

Parameters:
- Q, 3023: modulus. Must be < 2^W, and 2*Q must be < 2^(W+1).
- W, 12: residue width, matching the reducer's dout_r.
- FRAME_LEN, 256: residues per frame. Must be >= 1.
- CW, 8: frame counter width, ceil(log2(FRAME_LEN)). Must be >= 1.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- clr  in  1  Synchronous frame abort. Discards the partial frame and clears err.
- din_r  in  W  Residue from the reducer, nominally 0..Q-1.
- din_valid  in  1  din_r is valid.
- din_ready  out  1  Block accepts din_r this cycle.
- dout_sum  out  W  Frame sum mod Q.
- dout_valid  out  1  dout_sum is valid.
- dout_ready  in  1  Downstream accepts dout_sum.
- err  out  1  Sticky flag: an accepted residue was >= Q.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs and registers are cleared.
  - Registers: state=ACCUM, acc=0, cnt=0.
  - Outputs: dout_sum=0, dout_valid=0, err=0, din_ready=1.
- Clock and reset: one clock domain, clk, with asynchronous active-low reset rst_n.
- States:
  - ACCUM: din_ready=1, dout_valid=0.
  - OUT: din_ready=0, dout_valid=1.
- Input acceptance: a beat is accepted when din_valid && din_ready.
  - Normalise the input: x = (din_r >= Q) ? din_r - Q : din_r. This is a single subtraction, valid because din_r < 2Q.
  - Form s = acc + x (W+1 bits, s < 2Q), then acc_next = (s >= Q) ? s - Q : s.
- Counting in ACCUM:
  - If cnt != FRAME_LEN-1: acc <= acc_next, cnt <= cnt+1.
  - If cnt == FRAME_LEN-1: dout_sum <= acc_next, acc <= 0, cnt <= 0, go to OUT.
- Latency: dout_valid rises one cycle after the last beat is accepted.
- OUT state:
  - dout_sum is held stable while dout_valid=1 and dout_ready=0.
  - On dout_ready=1, go to ACCUM. din_ready returns the next cycle, giving one bubble cycle per frame.
- Error flag: err is set when an accepted din_r >= Q. It stays set until reset or clr. The out-of-range beat is still accumulated using its normalised value x.
- clr (synchronous, highest priority after reset):
  - Sets acc=0, cnt=0, err=0, dout_valid=0, state=ACCUM.
  - Any beat presented in the same cycle is not accumulated.
  - din_ready is forced to 0 in that cycle.
- FRAME_LEN=1: every accepted beat produces one output equal to its normalised value.
- Protocol assumption: din_r is sampled only on handshake; din_valid without din_ready has no effect.
- Asynchronous reset mid-frame or in OUT: the partial sum and any pending output are discarded.

Test Plan:
- Reset and single frame (FRAME_LEN=4): after reset, check dout_valid=0, din_ready=1, err=0. Send 3022, 3022, 1, 5 back-to-back with dout_ready=1 -> dout_sum=4, dout_valid=1 exactly one cycle after the 4th beat, err=0.
- Backpressure: same frame with dout_ready=0 for 5 cycles.
  - dout_sum must stay at 4 and din_ready must stay 0 throughout.
  - Raise dout_ready -> one handshake occurs, then din_ready=1 the next cycle.
- Wrap and zero (FRAME_LEN=4): send 1511, 1512, 0, 0 -> dout_sum=0. Send four beats of 0 -> 0.
- Out-of-range input (FRAME_LEN=4): send 4000, 10, 0, 0 -> err=1 after the first beat and dout_sum=987, since 4000-3023=977 and 977+10=987. err stays 1 through the next frame.
- clr mid-frame (FRAME_LEN=4):
  - Send 100, 200, then pulse clr with din_valid=1, din_r=50 in the same cycle -> that beat is dropped and err=0.
  - Next 7, 8, 9, 10 -> dout_sum=34.
- Random stress: 1000 frames with random valid/ready gaps, compared against a reference sum mod 3023.
  - No lost beats, no duplicated beats.
  - dout_sum is stable whenever dout_valid=1 and dout_ready=0.
